sram_ctrl: RTL
==============

# sram_ctrl

Synchronous front end for the asynchronous `sram` model. It accepts one read or write request at a time from the CPU bus over a ready/req handshake. It then sequences the SRAM's active-low strobes (`notCS`, `notOE`, `notWE`) and its tri-state data bus using programmable cycle counts, and returns read data with a one-cycle `done` pulse. It sits directly upstream of `sram` and drives all of its ports.

## Interface
- `DATA_WIDTH`, 16, width of the data word and of the SRAM data bus.
- `ADDR_WIDTH`, 16, width of the address.
- `SETUP_CYCLES`, 1, cycles from address/data valid to the `notWE` fall. Legal range 1..15.
- `WE_CYCLES`, 1, width of the `notWE` low pulse in cycles. Legal range 1..15.
- `HOLD_CYCLES`, 1, cycles that data and address stay driven after the `notWE` rise. Legal range 1..15.
- `READ_CYCLES`, 2, cycles with `notOE` low before read data is sampled. Legal range 1..15.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  request strobe; accepted only on a rising edge where `ready`=1.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  ADDR_WIDTH  request address; sampled with `req`.
- `wdata`  in  DATA_WIDTH  write data; sampled with `req`.
- `ready`  out  1  controller idle and able to accept a request.
- `done`  out  1  one-cycle pulse marking completion of the accepted transaction.
- `rdata`  out  DATA_WIDTH  last read result; valid from `done` of a read until the next read's `done`.
- `sramAddr`  out  ADDR_WIDTH  to `sram` addr.
- `sramData`  inout  DATA_WIDTH  to `sram` data; driven only during write states, `z` otherwise.
- `sramNotOE`, `sramNotWE`, `sramNotCS`  out  1 each  SRAM strobes, active low.

## Operation
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, RECOVER. A 4-bit down-counter times each timed state.
- IDLE:
  - `ready`=1. All strobes are high and the bus is `z`.
  - On `req`, latch `we`/`addr`/`wdata` into internal registers. Go to W_SETUP if `we`=1, else R_ACCESS.
  - Changes to the inputs after acceptance have no effect.
- W_SETUP (SETUP_CYCLES): `sramAddr`=latched addr, bus driven with latched data, `notCS`=0, `notWE`=1, `notOE`=1.
- W_PULSE (WE_CYCLES): as W_SETUP, but with `notWE`=0.
- W_HOLD (HOLD_CYCLES): as W_SETUP (`notWE`=1, data still driven).
- R_ACCESS (READ_CYCLES):
  - `notCS`=0, `notOE`=0, bus `z`.
  - On the edge leaving this state, capture `sramData` into `rdata`.
- RECOVER (1 cycle):
  - All strobes are high and the bus is `z`. `sramAddr` holds the latched address.
  - `done`=1. Next state is IDLE.
  - This state guarantees bus turnaround: the bus is never driven while `notOE`=0, and never driven in the cycle after `notOE` rises.
- `ready` = (state==IDLE) & !reset. A `req` arriving while `ready`=0 is ignored, not queued. The requester must hold it or re-issue it.
- `notWE` and `notOE` are never low simultaneously.
- All strobes come from registers and are glitch-free.
- `sramAddr` changes only in IDLE→W_SETUP/R_ACCESS transitions.

## Timing
- Reset values (applied asynchronously while `reset`=1): state IDLE, all strobes 1, bus `z`, `done`=0, `rdata`=0, `sramAddr`=0, `ready`=0 until `reset` falls.
- Write latency: accept edge → `done` high after SETUP+WE+HOLD+1 cycles. With defaults, `done` is high in cycle 4.
- Read latency: accept edge → `done` high after READ+1 cycles. With defaults, cycle 3.
- `ready` is high again in the cycle after `done`. Minimum request spacing is write 5 cycles and read 4 cycles with defaults.
- Back-to-back: a `req` held high continuously is accepted on the first edge of each IDLE cycle.
- Reset mid-transaction:
  - Strobes rise and the bus goes `z` immediately. No `done` is generated.
  - `rdata` is cleared.
  - SRAM contents at the in-flight write address are undefined.
- Counter: loaded with (N-1) on state entry. The state is left when the counter reaches 0. Parameter value 0 is illegal (the bench checks with an `initial` assertion).

## Test plan
Benches instantiate `sram` with DATA_WIDTH=4, ADDR_WIDTH=4 and MEMFILE "mem.lst" (addr 0 = 0xF, addr 1 = 0xE). Clock period is 100.
- Read addr 0, then addr 1 → `done` 3 cycles after each accept; `rdata`=0xF, then 0xE. `notOE` is low for exactly 2 cycles and `notWE` stays 1.
- Write data=i to addr=i for i=3..10, then read each back → every read returns i. Each write shows `notWE` low for exactly 1 cycle, with data stable from W_SETUP through W_HOLD.
- Hold `req`=1 with alternating `we` for 6 transactions → one accept per IDLE cycle, no lost or duplicated `done`. The bus is never driven while `notOE`=0.
- Assert `req` during W_PULSE → ignored; exactly one `done`, and no extra SRAM access.
- Assert `reset` during W_PULSE → `notWE`/`notCS` high and bus `z` before the next clock edge, no `done`. After release, `ready`=1, and a read of addr 0 still returns 0xF.
- Rerun with SETUP=2, WE=3, HOLD=2, READ=4 → write `done` 8 cycles after accept, read `done` 5 cycles after accept, data correct.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: synchronous sequencer for an asynchronous SRAM.
// Accepts one request at a time and drives the SRAM strobes, address and data bus with programmable timing.
module sram_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int SETUP_CYCLES = 1,
  parameter int WE_CYCLES    = 1,
  parameter int HOLD_CYCLES  = 1,
  parameter int READ_CYCLES  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] sramAddr,
  inout  wire  [DATA_WIDTH-1:0] sramData,
  output logic                  sramNotOE,
  output logic                  sramNotWE,
  output logic                  sramNotCS
);
  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, RECOVER} stateT;
  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] WE_LOAD    = 4'(WE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] READ_LOAD  = 4'(READ_CYCLES - 1);
  stateT                 state, nextState;
  logic [3:0]            cnt, nextCnt;
  logic [DATA_WIDTH-1:0] dataQ;
  logic                  driveEn;
  assign ready    = state == IDLE && !reset;
  assign sramData = driveEn ? dataQ : {DATA_WIDTH{1'bz}};
  always_comb begin
    nextState = state;
    nextCnt   = cnt - 4'd1;
    case (state)
      IDLE: begin
        nextState = req ? (we ? W_SETUP : R_ACCESS) : IDLE;
        nextCnt   = we ? SETUP_LOAD : READ_LOAD;
      end
      W_SETUP: if (cnt == 4'd0) begin
        nextState = W_PULSE;
        nextCnt   = WE_LOAD;
      end
      W_PULSE: if (cnt == 4'd0) begin
        nextState = W_HOLD;
        nextCnt   = HOLD_LOAD;
      end
      W_HOLD:   nextState = cnt == 4'd0 ? RECOVER : W_HOLD;
      R_ACCESS: nextState = cnt == 4'd0 ? RECOVER : R_ACCESS;
      default:  nextState = IDLE;
    endcase
  end
  // Strobes and bus enable are registered from the next state so they never glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      sramNotCS <= 1'b1;
      sramNotWE <= 1'b1;
      sramNotOE <= 1'b1;
      driveEn   <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      sramAddr  <= '0;
      dataQ     <= '0;
    end else begin
      state     <= nextState;
      cnt       <= nextCnt;
      sramNotCS <= nextState == IDLE || nextState == RECOVER;
      sramNotWE <= nextState != W_PULSE;
      sramNotOE <= nextState != R_ACCESS;
      driveEn   <= nextState inside {W_SETUP, W_PULSE, W_HOLD};
      done      <= nextState == RECOVER;
      if (state == IDLE && req) begin
        sramAddr <= addr;
        dataQ    <= wdata;
      end
      if (state == R_ACCESS && nextState == RECOVER) rdata <= sramData;
    end
  end
endmodule
